// File: rtl/arp_pkg.sv
// Shared definitions for the ARP transmit sequencer.
// Holds the FSM state encoding, the broadcast MAC and the ARP opcode constants.
package arp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE
    } arp_state_t;

    localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic        ARP_OP_REQ        = 1'b0;
    localparam logic        ARP_OP_RPLY       = 1'b1;

endpackage

// File: rtl/arp_retry_timer.sv
// Retry timer for unanswered ARP requests.
// Ports: clk, reset (async, active-high); start restarts the cycle counter
// from 0; stop halts it; clear halts it and zeroes the retry count.
// expire pulses when a resend is due; fail pulses when retries are used up.
// Both pulses are combinational and are valid in the final timer cycle.
module arp_retry_timer #(
    parameter int RETRY_CYCLES = 125_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    input  logic clear,
    output logic expire,
    output logic fail
);

    localparam int CW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(RETRY_CYCLES - 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    logic          running;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retries;
    logic          at_end;
    logic          halt;

    assign at_end = running & (cnt == LAST);
    // A stop or clear in the last cycle wins over the expiry.
    assign halt   = stop | clear;
    assign expire = at_end & ~halt & (retries < RMAX);
    assign fail   = at_end & ~halt & ~(retries < RMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            retries <= '0;
        end else if (clear) begin
            running <= 1'b0;
            cnt     <= '0;
            retries <= '0;
        end else if (stop) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (at_end) begin
            running <= 1'b0;
            cnt     <= '0;
            if (expire)
                retries <= retries + 1'b1;
        end else if (running) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arp_ctrl.sv
// ARP transmit sequencer: answers received requests and resolves target_ip.
// Ports: req_start/target_ip (resolve), rx_* (receiver), tx_done (framer),
// arp_tx_en/type, des_mac/ip (framer), busy, resolved(_mac), resolve_fail.
module arp_ctrl
    import arp_pkg::*;
#(
    parameter int RETRY_CYCLES = 125_000_000,
    parameter int MAX_RETRY    = 3,
    parameter int EN_HOLD      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_start,
    input  logic [31:0] target_ip,
    input  logic        rx_done,
    input  logic        rx_type,
    input  logic [47:0] rx_src_mac,
    input  logic [31:0] rx_src_ip,
    input  logic        tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        busy,
    output logic        resolved,
    output logic [47:0] resolved_mac,
    output logic        resolve_fail
);

    localparam int HW = (EN_HOLD > 1) ? $clog2(EN_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(EN_HOLD - 1);

    arp_state_t    state;
    logic [HW-1:0] hold;

    logic          rply_pend;
    logic [47:0]   rply_mac;
    logic [31:0]   rply_ip;
    logic          req_pend;
    logic [31:0]   tgt_ip;
    logic          awaiting;

    logic          rx_req;
    logic          match;
    logic          launch_rply;
    logic          launch_req;
    logic          tmr_start;
    logic          expire;
    logic          fail;

    assign rx_req      = rx_done & (rx_type == ARP_OP_REQ);
    // A new req_start discards any reply that arrives in the same cycle.
    assign match       = rx_done & (rx_type == ARP_OP_RPLY)
                       & (rx_src_ip == tgt_ip) & awaiting & ~req_start;
    // Replies always go before requests.
    assign launch_rply = (state == S_IDLE) & rply_pend;
    assign launch_req  = (state == S_IDLE) & ~rply_pend & req_pend;
    assign tmr_start   = (state == S_WAIT_DONE) & tx_done
                       & (arp_tx_type == ARP_OP_REQ) & awaiting & ~match;

    arp_retry_timer #(
        .RETRY_CYCLES (RETRY_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (tmr_start),
        .stop   (match),
        .clear  (req_start),
        .expire (expire),
        .fail   (fail)
    );

    // Pending flags and resolution state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rply_pend    <= 1'b0;
            rply_mac     <= '0;
            rply_ip      <= '0;
            req_pend     <= 1'b0;
            tgt_ip       <= '0;
            awaiting     <= 1'b0;
            resolved     <= 1'b0;
            resolved_mac <= '0;
            resolve_fail <= 1'b0;
        end else begin
            resolve_fail <= fail;

            // A fresh request overwrites the entry even while one launches;
            // the launching frame already took the old values.
            if (rx_req) begin
                rply_pend <= 1'b1;
                rply_mac  <= rx_src_mac;
                rply_ip   <= rx_src_ip;
            end else if (launch_rply) begin
                rply_pend <= 1'b0;
            end

            if (req_start | expire)
                req_pend <= 1'b1;
            else if (match | launch_req)
                req_pend <= 1'b0;

            if (req_start) begin
                tgt_ip   <= target_ip;
                resolved <= 1'b0;
                awaiting <= 1'b1;
            end else if (match) begin
                resolved     <= 1'b1;
                resolved_mac <= rx_src_mac;
                awaiting     <= 1'b0;
            end else if (fail) begin
                awaiting <= 1'b0;
            end
        end
    end

    // Launch sequencer; framer inputs stay put until tx_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            hold        <= '0;
            arp_tx_en   <= 1'b0;
            arp_tx_type <= ARP_OP_REQ;
            des_mac     <= '0;
            des_ip      <= '0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (launch_rply) begin
                        state       <= S_LAUNCH;
                        hold        <= '0;
                        arp_tx_en   <= 1'b1;
                        arp_tx_type <= ARP_OP_RPLY;
                        des_mac     <= rply_mac;
                        des_ip      <= rply_ip;
                        busy        <= 1'b1;
                    end else if (launch_req) begin
                        state       <= S_LAUNCH;
                        hold        <= '0;
                        arp_tx_en   <= 1'b1;
                        arp_tx_type <= ARP_OP_REQ;
                        des_mac     <= ETH_BROADCAST_MAC;
                        des_ip      <= tgt_ip;
                        busy        <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (hold == HOLD_LAST) begin
                        state     <= S_WAIT_DONE;
                        arp_tx_en <= 1'b0;
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    arp_tx_en <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed testbench for arp_ctrl with a short retry period.
// Covers reply, resolution, retry exhaustion, priority, same-cycle and reset.
module tb_arp_ctrl;

    logic        clk;
    logic        reset;
    logic        req_start;
    logic [31:0] target_ip;
    logic        rx_done;
    logic        rx_type;
    logic [47:0] rx_src_mac;
    logic [31:0] rx_src_ip;
    logic        tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        busy;
    logic        resolved;
    logic [47:0] resolved_mac;
    logic        resolve_fail;

    int checks;
    int failures;

    arp_ctrl #(
        .RETRY_CYCLES (100),
        .MAX_RETRY    (3),
        .EN_HOLD      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_start    (req_start),
        .target_ip    (target_ip),
        .rx_done      (rx_done),
        .rx_type      (rx_type),
        .rx_src_mac   (rx_src_mac),
        .rx_src_ip    (rx_src_ip),
        .tx_done      (tx_done),
        .arp_tx_en    (arp_tx_en),
        .arp_tx_type  (arp_tx_type),
        .des_mac      (des_mac),
        .des_ip       (des_ip),
        .busy         (busy),
        .resolved     (resolved),
        .resolved_mac (resolved_mac),
        .resolve_fail (resolve_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input int max, output int n);
        n = 0;
        while (!arp_tx_en && n < max) begin
            tick();
            n++;
        end
        check("en_timeout", {63'd0, arp_tx_en}, 64'd1);
    endtask

    task automatic finish_frame;
        repeat (4) tick();
        check("en_low", {63'd0, arp_tx_en}, 64'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic quiet(input int cyc, output int rises);
        rises = 0;
        repeat (cyc) begin
            tick();
            if (arp_tx_en || resolve_fail)
                rises++;
        end
    endtask

    initial begin
        int k;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        req_start  = 1'b0;
        target_ip  = '0;
        rx_done    = 1'b0;
        rx_type    = 1'b0;
        rx_src_mac = '0;
        rx_src_ip  = '0;
        tx_done    = 1'b0;
        repeat (3) tick();
        check("rst_en", {63'd0, arp_tx_en}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_mac", {16'd0, des_mac}, 64'd0);
        check("rst_resolved", {63'd0, resolved}, 64'd0);
        reset = 1'b0;
        tick();

        // Reply to a received request.
        rx_done    = 1'b1;
        rx_type    = 1'b0;
        rx_src_mac = 48'h000A_3501_0203;
        rx_src_ip  = 32'hC0A8_0166;
        tick();
        rx_done = 1'b0;
        check("rply_lat0", {63'd0, arp_tx_en}, 64'd0);
        tick();
        check("rply_type", {63'd0, arp_tx_type}, 64'd1);
        check("rply_mac", {16'd0, des_mac}, 64'h0000_000A_3501_0203);
        check("rply_ip", {32'd0, des_ip}, 64'hC0A8_0166);
        check("rply_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("rply_hold", {63'd0, arp_tx_en}, 64'd1);
            tick();
        end
        check("rply_drop", {63'd0, arp_tx_en}, 64'd0);
        check("rply_wait", {63'd0, busy}, 64'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("rply_idle", {63'd0, busy}, 64'd0);
        tick();

        // Resolution with no resend afterwards.
        req_start = 1'b1;
        target_ip = 32'hC0A8_0166;
        tick();
        req_start = 1'b0;
        wait_en(10, k);
        check("res_lat", k, 64'd1);
        check("res_type", {63'd0, arp_tx_type}, 64'd0);
        check("res_bcast", {16'd0, des_mac}, 64'h0000_FFFF_FFFF_FFFF);
        check("res_ip", {32'd0, des_ip}, 64'hC0A8_0166);
        finish_frame();
        repeat (10) tick();
        rx_done    = 1'b1;
        rx_type    = 1'b1;
        rx_src_mac = 48'h000A_3501_0203;
        rx_src_ip  = 32'hC0A8_0166;
        tick();
        rx_done = 1'b0;
        check("res_flag", {63'd0, resolved}, 64'd1);
        check("res_mac", {16'd0, resolved_mac}, 64'h0000_000A_3501_0203);
        quiet(150, k);
        check("res_noresend", k, 64'd0);

        // Retry exhaustion: four requests, then a single fail pulse.
        req_start = 1'b1;
        target_ip = 32'h0A00_0001;
        tick();
        req_start = 1'b0;
        check("rt_clr", {63'd0, resolved}, 64'd0);
        wait_en(10, k);
        for (int i = 0; i < 4; i++) begin
            check("rt_type", {63'd0, arp_tx_type}, 64'd0);
            check("rt_ip", {32'd0, des_ip}, 64'h0A00_0001);
            finish_frame();
            if (i < 3) begin
                wait_en(200, k);
                check("rt_gap", k, 64'd101);
            end
        end
        k = 0;
        while (!resolve_fail && k < 200) begin
            tick();
            k++;
        end
        check("rt_fail", {63'd0, resolve_fail}, 64'd1);
        check("rt_fail_gap", k, 64'd100);
        tick();
        check("rt_fail_pulse", {63'd0, resolve_fail}, 64'd0);
        quiet(150, k);
        check("rt_quiet", k, 64'd0);

        // Reply and request pending together: reply goes first.
        req_start  = 1'b1;
        target_ip  = 32'hC0A8_0101;
        rx_done    = 1'b1;
        rx_type    = 1'b0;
        rx_src_mac = 48'h0211_2233_4455;
        rx_src_ip  = 32'hC0A8_0105;
        tick();
        req_start = 1'b0;
        rx_done   = 1'b0;
        wait_en(10, k);
        check("pri_type1", {63'd0, arp_tx_type}, 64'd1);
        check("pri_mac1", {16'd0, des_mac}, 64'h0000_0211_2233_4455);
        check("pri_ip1", {32'd0, des_ip}, 64'hC0A8_0105);
        finish_frame();
        wait_en(10, k);
        check("pri_type2", {63'd0, arp_tx_type}, 64'd0);
        check("pri_mac2", {16'd0, des_mac}, 64'h0000_FFFF_FFFF_FFFF);
        check("pri_ip2", {32'd0, des_ip}, 64'hC0A8_0101);
        finish_frame();

        // Matching reply in the same cycle as a new req_start is dropped.
        req_start  = 1'b1;
        target_ip  = 32'hC0A8_0202;
        rx_done    = 1'b1;
        rx_type    = 1'b1;
        rx_src_mac = 48'h0033_4455_6677;
        rx_src_ip  = 32'hC0A8_0101;
        tick();
        req_start = 1'b0;
        rx_done   = 1'b0;
        check("sc_resolved", {63'd0, resolved}, 64'd0);
        wait_en(10, k);
        check("sc_type", {63'd0, arp_tx_type}, 64'd0);
        check("sc_ip", {32'd0, des_ip}, 64'hC0A8_0202);
        finish_frame();
        check("sc_resolved2", {63'd0, resolved}, 64'd0);

        // Reset while waiting for tx_done.
        rx_done    = 1'b1;
        rx_type    = 1'b0;
        rx_src_mac = 48'h0011_2233_4455;
        rx_src_ip  = 32'hC0A8_0107;
        tick();
        rx_done = 1'b0;
        wait_en(10, k);
        repeat (4) tick();
        check("rm_wait", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        check("rm_en", {63'd0, arp_tx_en}, 64'd0);
        check("rm_type", {63'd0, arp_tx_type}, 64'd0);
        check("rm_mac", {16'd0, des_mac}, 64'd0);
        check("rm_ip", {32'd0, des_ip}, 64'd0);
        check("rm_busy", {63'd0, busy}, 64'd0);
        check("rm_rmac", {16'd0, resolved_mac}, 64'd0);
        reset = 1'b0;
        quiet(250, k);
        check("rm_quiet", k, 64'd0);
        check("rm_idle", {63'd0, busy}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arp_ctrl.md
# arp_ctrl

Sequencer for the ARP transmitter in the UDP/OSD Ethernet path. It sits between the ARP receiver and the ARP transmit framer. It turns received ARP requests into replies and resolves a target IP with periodic broadcast requests. It drives the framer's enable, type and address inputs with correct hold and ordering, then latches the resolved MAC for the UDP layer.

## Interface
- `RETRY_CYCLES`, 125_000_000: clocks between an unanswered request's `tx_done` and its resend (1 s at 125 MHz).
- `MAX_RETRY`, 3: resends after the first request before failing.
- `EN_HOLD`, 4: cycles `arp_tx_en` is held high per launch. Must be ≥3 to cover the framer's 2-flop edge detector.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_start`  in  1  one-cycle pulse: resolve `target_ip`.
- `target_ip`  in  32  IP to resolve; sampled on `req_start`.
- `rx_done`  in  1  one-cycle pulse: valid ARP frame received.
- `rx_type`  in  1  0 = request received, 1 = reply received.
- `rx_src_mac`  in  48  sender MAC of received frame; valid with `rx_done`.
- `rx_src_ip`  in  32  sender IP of received frame; valid with `rx_done`.
- `tx_done`  in  1  one-cycle pulse from framer: frame fully sent.
- `arp_tx_en`  out  1  launch to framer.
- `arp_tx_type`  out  1  0 = request, 1 = reply.
- `des_mac`  out  48  destination MAC to framer.
- `des_ip`  out  32  destination IP to framer.
- `busy`  out  1  FSM not in IDLE.
- `resolved`  out  1  level: `resolved_mac` valid for the current target.
- `resolved_mac`  out  48  MAC answering `target_ip`.
- `resolve_fail`  out  1  one-cycle pulse: retries exhausted.

## Operation
- **Pending flags.**
  - `rply_pend` is set by `rx_done & ~rx_type`. Sender MAC/IP are latched into a single entry; a later request overwrites an unlaunched entry.
  - `req_pend` is set by `req_start`, or by retry-timer expiry while retries remain.
- **FSM states:** IDLE, LAUNCH, WAIT_DONE.
  - IDLE → LAUNCH when any flag is pending. Reply has priority over request. The chosen flag is cleared and outputs are loaded in the same cycle.
  - Reply launch: `arp_tx_type`=1, `des_mac`=latched sender MAC, `des_ip`=latched sender IP.
  - Request launch: `arp_tx_type`=0, `des_mac`=48'hFFFF_FFFF_FFFF, `des_ip`=`target_ip`.
  - LAUNCH holds `arp_tx_en`=1 for `EN_HOLD` cycles, then goes to WAIT_DONE with `arp_tx_en`=0.
  - WAIT_DONE → IDLE on `tx_done`. A `tx_done` seen in IDLE or LAUNCH is ignored.
- **Resolution.**
  - `req_start` clears `resolved`, loads the target, zeroes the retry count and sets `awaiting`.
  - `rx_done & rx_type & (rx_src_ip == target_ip) & awaiting` sets `resolved`, latches `resolved_mac`, clears `awaiting` and `req_pend`, and stops the timer.
  - A matching reply arriving during a request's LAUNCH/WAIT_DONE lets that frame finish; no resend follows.
- **Retry timer.**
  - Starts from 0 on `tx_done` of a request while `awaiting`.
  - At `RETRY_CYCLES-1`: if retry count < `MAX_RETRY`, increment the count and set `req_pend`.
  - Otherwise, pulse `resolve_fail` and clear `awaiting`.
  - The timer keeps running while replies are sent.
- **Simultaneous events.**
  - `req_start` with `rx_done`: `req_start` wins and a same-cycle reply match is discarded. A same-cycle received request is still latched.
  - `req_start` while busy: takes effect; the new request launches after the current frame.
  - `des_*` and `arp_tx_type` are stable from the `arp_tx_en` rise until `tx_done`.

## Timing
- **Reset values:** `arp_tx_en`=0, `arp_tx_type`=0, `des_mac`=0, `des_ip`=0, `busy`=0, `resolved`=0, `resolved_mac`=0, `resolve_fail`=0. All flags, counters and the FSM clear.
- **Reset mid-frame:** asserting `reset` aborts immediately with no resend after release.
- **Launch latency:** event in cycle N (IDLE) → flag set at N+1 → `arp_tx_en` high at N+2 for `EN_HOLD` cycles.
- **`resolved`:** rises one cycle after the matching `rx_done`.
- **Retry spacing:** exactly `RETRY_CYCLES` clocks from `tx_done` to `req_pend` set.
- **`resolve_fail`:** fires `RETRY_CYCLES` after the (`MAX_RETRY`+1)-th request's `tx_done`.

## Structure
- **Shared package `arp_pkg`:** FSM state encoding, `ETH_BROADCAST_MAC`=48'hFFFF_FFFF_FFFF, `ARP_OP_REQ`=0 / `ARP_OP_RPLY`=1 type constants.
- **Sub-module `arp_retry_timer`:** a single instance containing the cycle counter, retry counter and expire/fail outputs, with start/stop/clear inputs.

## Test plan
- **Reply to received request.** `rx_done`, `rx_type`=0, MAC 00-0A-35-01-02-03, IP 192.168.1.102 → `arp_tx_en` high 4 cycles with `arp_tx_type`=1 and those `des_*`; `busy` drops the cycle after `tx_done`.
- **Resolution.** `req_start` with 192.168.1.102 → broadcast request sent; a reply from that IP with MAC 00-0A-35-01-02-03 → `resolved`=1 and `resolved_mac` matches; no resend after `RETRY_CYCLES`.
- **Retry exhaustion.** `RETRY_CYCLES`=100, no reply → exactly 4 requests spaced 100 cycles after each `tx_done`, then one `resolve_fail` pulse.
- **Priority.** Request launch pending at the same time as a received ARP request → the reply frame goes first, then the request; both sets of `des_*` are correct.
- **Same-cycle events.** Matching reply in the same cycle as a new `req_start` → `resolved` stays 0 and a request for the new IP is sent.
- **Reset mid-frame.** `reset` asserted while in WAIT_DONE → all outputs return to reset values next edge; no launch after release.
